// File: rtl/cpu_mobo_bus_arb.sv
// cpu_mobo_bus_arb: two-requester arbiter and sequencer for the mobo bus.
// Requester 0 is instruction fetch and requester 1 is data read/write. The
// winner's address and data are latched, and the bus strobe is held until
// mobo_stat acknowledges or the timeout expires. Read data or an error is then
// returned to the winner with a one-cycle done pulse.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   req[1:0], we[1:0]     per-requester request and write-enable
//   addr0/1, wdata0/1     per-requester address and write data
//   gnt[1:0]              one-cycle pulse when a request is accepted
//   done[1:0], err        one-cycle completion pulse; err flags a bus error or timeout
//   rdata                 read data, held until the next completed read
//   mobo_ctrl             [0] read strobe, [1] write strobe
//   mobo_addr, mobo_wdata latched address and write data of the active transaction
//   mobo_stat             [0] ack, [1] bus error (only meaningful with ack)
//   mobo_rdata            read data, valid with ack
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module cpu_mobo_bus_arb #(
   parameter int unsigned word_width = `WORD_WIDTH,
   parameter int unsigned TIMEOUT    = 16,
   parameter int unsigned TMR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [word_width-1:0] addr0,
   input  logic [word_width-1:0] addr1,
   input  logic [word_width-1:0] wdata0,
   input  logic [word_width-1:0] wdata1,
   output logic [1:0]            gnt,
   output logic [1:0]            done,
   output logic                  err,
   output logic [word_width-1:0] rdata,
   output logic [word_width-1:0] mobo_ctrl,
   output logic [word_width-1:0] mobo_addr,
   output logic [word_width-1:0] mobo_wdata,
   input  logic [word_width-1:0] mobo_stat,
   input  logic [word_width-1:0] mobo_rdata
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   // Only compared when TIMEOUT != 0, so the wrap at TIMEOUT == 0 is harmless.
   localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT - 1);

   state_e                state_q, state_d;
   logic                  lp_q, lp_d;
   logic                  win_q, win_d;
   logic                  we_q, we_d;
   logic [word_width-1:0] addr_q, addr_d;
   logic [word_width-1:0] wdata_q, wdata_d;
   logic [TMR_W-1:0]      timer_q, timer_d;
   logic [word_width-1:0] rdata_q, rdata_d;
   logic [1:0]            gnt_q, gnt_d;
   logic [1:0]            done_q, done_d;
   logic                  err_q, err_d;
   logic                  rd_stb_q, rd_stb_d;
   logic                  wr_stb_q, wr_stb_d;
   logic                  pick;

   always_comb begin
      state_d  = state_q;
      lp_d     = lp_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      timer_d  = timer_q;
      rdata_d  = rdata_q;
      gnt_d    = '0;
      done_d   = '0;
      err_d    = 1'b0;
      rd_stb_d = 1'b0;
      wr_stb_d = 1'b0;
      pick     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|req) begin
               // On a conflict the requester that did not win last time goes first.
               pick        = (req == 2'b11) ? ~lp_q : req[1];
               win_d       = pick;
               lp_d        = pick;
               we_d        = we[pick];
               addr_d      = pick ? addr1 : addr0;
               wdata_d     = we[pick] ? (pick ? wdata1 : wdata0) : '0;
               gnt_d[pick] = 1'b1;
               rd_stb_d    = ~we[pick];
               wr_stb_d    = we[pick];
               timer_d     = '0;
               state_d     = StBusy;
            end
         end
         StBusy: begin
            if (mobo_stat[0]) begin
               // An ack takes priority over a timeout that expires in the same cycle.
               done_d[win_q] = 1'b1;
               err_d         = mobo_stat[1];
               if (!we_q) rdata_d = mobo_rdata;
               state_d       = StDone;
            end else if (TIMEOUT != 0 && timer_q == TmrLast) begin
               done_d[win_q] = 1'b1;
               err_d         = 1'b1;
               state_d       = StDone;
            end else begin
               rd_stb_d = ~we_q;
               wr_stb_d = we_q;
               if (timer_q != '1) timer_d = timer_q + TMR_W'(1);
            end
         end
         StDone: begin
            // Dead cycle so that the requester can drop req.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         lp_q     <= 1'b1;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         timer_q  <= '0;
         rdata_q  <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         err_q    <= 1'b0;
         rd_stb_q <= 1'b0;
         wr_stb_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         lp_q     <= lp_d;
         win_q    <= win_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         timer_q  <= timer_d;
         rdata_q  <= rdata_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rd_stb_q <= rd_stb_d;
         wr_stb_q <= wr_stb_d;
      end
   end

   assign gnt        = gnt_q;
   assign done       = done_q;
   assign err        = err_q;
   assign rdata      = rdata_q;
   assign mobo_ctrl  = {{(word_width-2){1'b0}}, wr_stb_q, rd_stb_q};
   assign mobo_addr  = addr_q;
   assign mobo_wdata = wdata_q;

endmodule

// File: tb/tb_cpu_mobo_bus_arb.sv
// Self-checking bench for cpu_mobo_bus_arb: directed scenarios plus randomized
// transactions, checked against a transaction-level model of the arbiter.
module tb_cpu_mobo_bus_arb;

   localparam int unsigned W  = 32;
   localparam int unsigned TO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req, we, gnt, done;
   logic         err;
   logic [W-1:0] addr0, addr1, wdata0, wdata1;
   logic [W-1:0] rdata, mobo_ctrl, mobo_addr, mobo_wdata, mobo_stat, mobo_rdata;
   logic [W-1:0] stat_drv;
   logic         auto_ack;

   int           n_checks = 0;
   int           n_fail   = 0;
   int           lp_m;
   logic [W-1:0] rdata_m;

   // With auto_ack set, the bus acks in the same cycle as any strobe.
   assign mobo_stat = auto_ack ? {{(W-1){1'b0}}, |mobo_ctrl[1:0]} : stat_drv;

   cpu_mobo_bus_arb #(
      .word_width(W),
      .TIMEOUT   (TO),
      .TMR_W     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mobo_ctrl (mobo_ctrl),
      .mobo_addr (mobo_addr),
      .mobo_wdata(mobo_wdata),
      .mobo_stat (mobo_stat),
      .mobo_rdata(mobo_rdata)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One transaction, entered and left on a negedge. ack_dly is the number of
   // strobe cycles before the ack cycle (-1 = never ack). exp_lat > 0 checks
   // the number of cycles from raising req to seeing gnt.
   task automatic run_txn(input logic [1:0] pat, input logic [1:0] wev,
                          input logic [W-1:0] a0, input logic [W-1:0] a1,
                          input logic [W-1:0] d0, input logic [W-1:0] d1,
                          input int ack_dly, input logic berr, input logic [W-1:0] rd,
                          input int exp_lat, input bit drop_early);
      int           w, cyc, strobes, exp_strobes;
      bit           seen, timed_out;
      logic [W-1:0] ctrl_exp, addr_exp, wd_exp;
      w        = (pat == 2'b11) ? (1 - lp_m) : (pat[1] ? 1 : 0);
      ctrl_exp = wev[w] ? 32'h2 : 32'h1;
      addr_exp = (w == 1) ? a1 : a0;
      wd_exp   = wev[w] ? ((w == 1) ? d1 : d0) : '0;
      timed_out   = !(ack_dly >= 0 && ack_dly < int'(TO));
      exp_strobes = timed_out ? int'(TO) : ack_dly + 1;

      req = pat; we = wev; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      cyc = 0; seen = 0;
      while (!seen && cyc < 8) begin
         @(negedge clk);
         cyc++;
         if (gnt != 0) seen = 1;
      end
      check_eq("gnt_seen", 32'(seen), 1);
      if (seen) begin
         if (exp_lat > 0) check_eq("gnt_latency", cyc, exp_lat);
         check_eq("gnt_onehot", 32'(gnt), 1 << w);
         lp_m = w;
         if (drop_early) req = 2'b00;
         strobes = 0; cyc = 0; seen = 0;
         while (!seen && cyc < int'(TO) + 8) begin
            check_eq("strobe_ctrl", mobo_ctrl, ctrl_exp);
            check_eq("strobe_addr", mobo_addr, addr_exp);
            check_eq("strobe_wdata", mobo_wdata, wd_exp);
            if (strobes == ack_dly) begin
               stat_drv   = {{(W-2){1'b0}}, berr, 1'b1};
               mobo_rdata = rd;
            end else begin
               stat_drv = '0;
            end
            strobes++;
            @(negedge clk);
            cyc++;
            if (done != 0) seen = 1;
         end
         stat_drv = '0;
         check_eq("done_seen", 32'(seen), 1);
         check_eq("done_onehot", 32'(done), 1 << w);
         check_eq("done_err", 32'(err), timed_out ? 1 : 32'(berr));
         check_eq("done_ctrl", mobo_ctrl, 0);
         check_eq("strobe_cycles", strobes, exp_strobes);
         if (!timed_out && !wev[w]) rdata_m = rd;
         check_eq("rdata", rdata, rdata_m);
      end
      req = 2'b00;
      @(negedge clk);
      check_eq("dead_done", 32'(done), 0);
      check_eq("dead_gnt", 32'(gnt), 0);
      check_eq("dead_err", 32'(err), 0);
      check_eq("dead_ctrl", mobo_ctrl, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int last, k;
      rst = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      stat_drv = '0; mobo_rdata = '0; auto_ack = 1'b0;
      lp_m = 1; rdata_m = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_gnt", 32'(gnt), 0);
      check_eq("rst_done", 32'(done), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_ctrl", mobo_ctrl, 0);
      check_eq("rst_addr", mobo_addr, 0);
      check_eq("rst_wdata", mobo_wdata, 0);
      rst = 1'b0;

      // Read with ack three cycles after the strobe.
      run_txn(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 3, 1'b0, 32'hDEADBEEF, 1, 0);
      // Write from requester 1.
      run_txn(2'b10, 2'b10, 32'h0, 32'h20, 32'h0, 32'h55AA, 2, 1'b0, 32'h12345678, 0, 0);
      // Timeout, then ack in the very last allowed cycle.
      run_txn(2'b01, 2'b00, 32'h30, 32'h0, 32'h0, 32'h0, -1, 1'b0, 32'h0, 0, 0);
      run_txn(2'b10, 2'b00, 32'h0, 32'h34, 32'h0, 32'h0, int'(TO) - 1, 1'b0, 32'hCAFE, 0, 0);
      // Bus error.
      run_txn(2'b01, 2'b01, 32'h40, 32'h0, 32'h77, 32'h0, 0, 1'b1, 32'h9, 0, 0);

      // A stray ack in idle must not produce a done.
      @(negedge clk);
      stat_drv = 32'h3;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("stray_ack_done", 32'(done), 0);
      end
      stat_drv = '0;
      @(negedge clk);

      // Held conflict with immediate acks: grants alternate, three cycles apart.
      auto_ack = 1'b1; mobo_rdata = 32'hA5A5A5A5; we = 2'b00; req = 2'b11;
      last = -1; k = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (gnt != 0) begin
            check_eq("conf_gnt", 32'(gnt), 1 << (1 - lp_m));
            lp_m = 1 - lp_m;
            if (last >= 0) check_eq("conf_gap", c - last, 3);
            last = c;
            k++;
         end
      end
      check_eq("conf_count", k, 6);
      req = 2'b00;
      repeat (4) @(negedge clk);
      auto_ack = 1'b0;
      rdata_m = 32'hA5A5A5A5;
      check_eq("conf_rdata", rdata, rdata_m);

      // Asynchronous reset in the middle of a transaction.
      req = 2'b01; we = 2'b00; addr0 = 32'h50;
      @(negedge clk);
      check_eq("pre_rst_gnt", 32'(gnt), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_ctrl", mobo_ctrl, 0);
      check_eq("async_rst_gnt", 32'(gnt), 0);
      check_eq("async_rst_done", 32'(done), 0);
      req = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lp_m = 1; rdata_m = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("post_rst_done", 32'(done), 0);
      end
      check_eq("post_rst_rdata", rdata, 0);
      run_txn(2'b11, 2'b00, 32'h60, 32'h64, 32'h0, 32'h0, 1, 1'b0, 32'h600D, 1, 0);

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         logic [1:0] pat;
         int         dly;
         pat = 2'($urandom_range(1, 3));
         dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5));
         run_txn(pat, 2'($urandom), $urandom, $urandom, $urandom, $urandom, dly,
                 1'($urandom_range(0, 3) == 0), $urandom, 0, $urandom_range(0, 3) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
